irq_arbiter: RTL

Interrupt request arbiter that sits between the external interrupt pins and the pipeline's interrupt injection sequencer. It edge-detects and latches up to NUM_SRC interrupt lines, applies a per-source mask, and selects one pending source by fixed priority. It then hands that source's interrupt vector table (IVT) address to the injector over a req/ack handshake and blocks further requests until the service routine signals return. The injector is single-ported and non-nesting; this block is the only requester it sees.

---
 rtl/irq_arbiter_if.sv | 31 +++
 rtl/irq_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: bundle between the interrupt pins / injector and the arbiter.
//   irq_in, irq_mask    : raw interrupt lines and per-source select mask
//   int_ack, rti_done   : injector acceptance and return-from-interrupt pulse
//   int_req, int_vector : request and IVT address toward the injector
//   int_src, in_service : selected source index and service-in-progress flag
//   pending, drop_count : latched requests and saturating lost-edge count
// Modport slave is the arbiter side; master is the pins/injector side.
interface irq_arbiter_if #(
   parameter int NUM_SRC = 4
);
   logic [NUM_SRC-1:0] irq_in;
   logic [NUM_SRC-1:0] irq_mask;
   logic               int_ack;
   logic               rti_done;
   logic               int_req;
   logic [31:0]        int_vector;
   logic [2:0]         int_src;
   logic               in_service;
   logic [NUM_SRC-1:0] pending;
   logic [7:0]         drop_count;

   modport slave (
      input  irq_in, irq_mask, int_ack, rti_done,
      output int_req, int_vector, int_src, in_service, pending, drop_count
   );

   modport master (
      output irq_in, irq_mask, int_ack, rti_done,
      input  int_req, int_vector, int_src, in_service, pending, drop_count
   );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-detects and latches interrupt lines, masks them, picks the
// lowest pending index and hands its IVT address to a single non-nesting
// injector over req/ack, then waits for rti_done before the next request.
//   clk : system clock (rising edge)
//   rst : synchronous, active-high reset
//   bus : irq_arbiter_if.slave (see interface header for signal list)
// All outputs are registered.
module irq_arbiter #(
   parameter int          NUM_SRC    = 4,
   parameter logic [31:0] IVT_BASE   = 32'h0000_0000,
   parameter logic [31:0] VEC_STRIDE = 32'd2
) (
   input logic           clk,
   input logic           rst,
   irq_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t             r_state;
   logic [NUM_SRC-1:0] r_irq_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic [7:0]         r_drop_count;
   logic               r_req;
   logic [31:0]        r_vector;
   logic [2:0]         r_src;
   logic               r_in_service;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_onehot;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic               w_sel_vld;
   logic [2:0]         w_sel_idx;
   logic [31:0]        w_vec;
   logic               w_drop;

   assign w_edge = bus.irq_in & ~r_irq_prev;
   assign w_elig = r_pending & ~bus.irq_mask;

   // Scan from the top down so the lowest eligible index is the one left standing.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      w_onehot  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = 3'(i);
            w_onehot  = '0;
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Selection only clears pending when the FSM actually takes it in IDLE.
   assign w_clr         = (r_state == S_IDLE && w_sel_vld) ? w_onehot : '0;
   // OR-ing the edge in last makes a same-cycle new edge survive the clear.
   assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
   // Edge into an already-pending source that is not being dispatched is lost.
   assign w_drop        = |(w_edge & r_pending & ~w_clr);
   assign w_vec         = IVT_BASE + (32'(w_sel_idx) * VEC_STRIDE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_irq_prev   <= '1;   // lines held high through reset do not fire
         r_pending    <= '0;
         r_drop_count <= '0;
         r_req        <= 1'b0;
         r_vector     <= '0;
         r_src        <= '0;
         r_in_service <= 1'b0;
      end else begin
         r_irq_prev <= bus.irq_in;
         r_pending  <= w_pending_nxt;
         if (w_drop && r_drop_count != 8'hFF)
            r_drop_count <= r_drop_count + 8'd1;
         case (r_state)
            S_IDLE: begin
               if (w_sel_vld) begin
                  r_src    <= w_sel_idx;
                  r_vector <= w_vec;
                  r_req    <= 1'b1;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               // Mask changes here do not withdraw the request.
               if (bus.int_ack) begin
                  r_req        <= 1'b0;
                  r_in_service <= 1'b1;
                  r_state      <= S_SERVICE;
               end
            end
            S_SERVICE: begin
               if (bus.rti_done) begin
                  r_in_service <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.int_req    = r_req;
   assign bus.int_vector = r_vector;
   assign bus.int_src    = r_src;
   assign bus.in_service = r_in_service;
   assign bus.pending    = r_pending;
   assign bus.drop_count = r_drop_count;
endmodule
